// File: rtl/msg_tx_arbiter.sv
// rtl/msg_tx_arbiter.sv - round-robin message arbiter framing SYNC/LEN/payload/CHK onto a byte stream
module msg_tx_arbiter #(
    parameter int         NUM_SRC   = 4,
    parameter int         SRC_W     = $clog2(NUM_SRC),
    parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_SRC-1:0]   src_have_msg,
    input  logic [8*NUM_SRC-1:0] src_len,
    input  logic [8*NUM_SRC-1:0] src_data,
    output logic [NUM_SRC-1:0]   src_rdreq,
    output logic [7:0]           tx_data,
    output logic                 tx_valid,
    input  logic                 tx_ready,
    output logic                 busy,
    output logic [SRC_W-1:0]     cur_src
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_LEN,
        S_PAY,
        S_CHK
    } state_t;

    state_t           state_q, state_d;
    logic [SRC_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [SRC_W-1:0] cur_src_q, cur_src_d;
    logic [7:0]       len_q, len_d;
    logic [7:0]       chk_q, chk_d;
    logic [7:0]       cnt_q, cnt_d;

    logic             grant_found;
    logic [SRC_W-1:0] grant_idx;
    logic [SRC_W:0]   rr_sum;
    logic [7:0]       head_byte;
    logic [7:0]       grant_len;

    // Round-robin search: first requester strictly after the last served source, wrapping.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        rr_sum      = '0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            rr_sum = {1'b0, rr_ptr_q} + (SRC_W+1)'(k);
            if (rr_sum >= (SRC_W+1)'(NUM_SRC)) begin
                rr_sum = rr_sum - (SRC_W+1)'(NUM_SRC);
            end
            if (!grant_found && src_have_msg[rr_sum[SRC_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = rr_sum[SRC_W-1:0];
            end
        end
    end

    // Select the granted source's head byte and the candidate's length from the packed buses.
    always_comb begin
        head_byte = '0;
        grant_len = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (cur_src_q == SRC_W'(i)) begin
                head_byte = src_data[i*8 +: 8];
            end
            if (grant_idx == SRC_W'(i)) begin
                grant_len = src_len[i*8 +: 8];
            end
        end
    end

    // Frame sequencing, byte output and pop strobes; pops are suppressed while rst is high.
    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        cur_src_d = cur_src_q;
        len_d     = len_q;
        chk_d     = chk_q;
        cnt_d     = cnt_q;
        tx_valid  = 1'b0;
        tx_data   = '0;
        src_rdreq = '0;
        case (state_q)
            S_IDLE: begin
                if (grant_found) begin
                    cur_src_d = grant_idx;
                    len_d     = grant_len;
                    chk_d     = grant_len;
                    cnt_d     = '0;
                    state_d   = S_HDR;
                end
            end
            S_HDR: begin
                tx_valid = 1'b1;
                tx_data  = SYNC_BYTE;
                if (tx_ready) begin
                    state_d = S_LEN;
                end
            end
            S_LEN: begin
                tx_valid = 1'b1;
                tx_data  = len_q;
                if (tx_ready) begin
                    state_d = (len_q != 8'd0) ? S_PAY : S_CHK;
                end
            end
            S_PAY: begin
                tx_valid = 1'b1;
                tx_data  = head_byte;
                if (tx_ready) begin
                    src_rdreq[cur_src_q] = !rst;
                    chk_d = chk_q ^ head_byte;
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q == len_q - 8'd1) begin
                        state_d = S_CHK;
                    end
                end
            end
            S_CHK: begin
                tx_valid = 1'b1;
                tx_data  = chk_q;
                if (tx_ready) begin
                    // An empty message still needs one pop so its source drops have_msg.
                    if (len_q == 8'd0) begin
                        src_rdreq[cur_src_q] = !rst;
                    end
                    rr_ptr_d = cur_src_q;
                    state_d  = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers; reset points rr_ptr at the last source so source 0 wins first.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            rr_ptr_q  <= SRC_W'(NUM_SRC - 1);
            cur_src_q <= '0;
            len_q     <= '0;
            chk_q     <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            cur_src_q <= cur_src_d;
            len_q     <= len_d;
            chk_q     <= chk_d;
            cnt_q     <= cnt_d;
        end
    end

    assign busy    = (state_q != S_IDLE);
    assign cur_src = cur_src_q;

endmodule

// File: tb/tb_msg_tx_arbiter.sv
// tb/tb_msg_tx_arbiter.sv - scoreboard bench for msg_tx_arbiter with modelled sources
module tb_msg_tx_arbiter;
    localparam int NUM_SRC = 4;
    localparam int SRC_W   = 2;
    localparam int MAXM    = 16;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [NUM_SRC-1:0]   src_have_msg;
    logic [8*NUM_SRC-1:0] src_len;
    logic [8*NUM_SRC-1:0] src_data;
    logic [NUM_SRC-1:0]   src_rdreq;
    logic [7:0]           tx_data;
    logic                 tx_valid;
    logic                 tx_ready;
    logic                 busy;
    logic [SRC_W-1:0]     cur_src;

    msg_tx_arbiter #(.NUM_SRC(NUM_SRC), .SRC_W(SRC_W), .SYNC_BYTE(8'hA5)) dut (
        .clk          (clk),
        .rst          (rst),
        .src_have_msg (src_have_msg),
        .src_len      (src_len),
        .src_data     (src_data),
        .src_rdreq    (src_rdreq),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .busy         (busy),
        .cur_src      (cur_src)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Source model: per-source ring of messages, read position within the head message.
    logic [7:0]         mdat [NUM_SRC][MAXM][256];
    int                 mlen [NUM_SRC][MAXM];
    int                 hd   [NUM_SRC];
    int                 tl   [NUM_SRC];
    int                 pos  [NUM_SRC];
    logic [NUM_SRC-1:0] drop;
    int                 rdy_mode;
    int                 rdy_phase;

    // Reference model: expected frame bytes, whether each accept pops, grant bookkeeping.
    logic [7:0] exp_q [$];
    bit         pop_q [$];
    bit         m_busy = 1'b0;
    int         m_src  = 0;
    int         m_last = NUM_SRC - 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive();
        int m;
        int n;
        for (int s = 0; s < NUM_SRC; s++) begin
            m = hd[s] % MAXM;
            n = mlen[s][m];
            src_have_msg[s]     = (hd[s] != tl[s]) && !drop[s];
            src_len[s*8 +: 8]   = (hd[s] != tl[s]) ? n[7:0] : 8'h00;
            src_data[s*8 +: 8]  = (hd[s] != tl[s]) ? mdat[s][m][pos[s]] : 8'h00;
        end
    endtask

    task automatic enq(input int s, input int n, input logic [7:0] b0, input logic [7:0] b1,
                       input logic [7:0] b2);
        int m;
        m = tl[s] % MAXM;
        mlen[s][m] = n;
        for (int i = 0; i < n; i++) begin
            mdat[s][m][i] = (i == 0) ? b0 : (i == 1) ? b1 : (i == 2) ? b2 : 8'($urandom);
        end
        tl[s]++;
        drive();
    endtask

    // One clock: sample pops mid-cycle, apply them just after the edge, then set new inputs.
    task automatic tick();
        logic [NUM_SRC-1:0] rd;
        int m;
        @(negedge clk);
        rd = src_rdreq;
        @(posedge clk);
        #1;
        for (int s = 0; s < NUM_SRC; s++) begin
            if (rd[s] && hd[s] != tl[s]) begin
                m = hd[s] % MAXM;
                if (mlen[s][m] == 0 || pos[s] + 1 >= mlen[s][m]) begin
                    hd[s]++;
                    pos[s] = 0;
                end else begin
                    pos[s]++;
                end
            end
        end
        case (rdy_mode)
            0: tx_ready = 1'b1;
            1: begin
                tx_ready = (rdy_phase % 3 == 0);
                rdy_phase++;
            end
            default: tx_ready = 1'($urandom_range(0, 1));
        endcase
        drive();
    endtask

    function automatic bit pending();
        bit p;
        p = 1'b0;
        for (int s = 0; s < NUM_SRC; s++) begin
            if (hd[s] != tl[s]) p = 1'b1;
        end
        return p;
    endfunction

    task automatic wait_idle(input int budget);
        int c;
        c = 0;
        while (c < budget && (m_busy || pending())) begin
            tick();
            c++;
        end
        chk("idle_timeout", 32'(c >= budget), 0);
        tick();
    endtask

    // Grant: first requester after the last served one (mod NUM_SRC); push its whole frame.
    task automatic model_grant();
        int         s;
        int         m;
        int         n;
        logic [7:0] c;
        for (int k = 1; k <= NUM_SRC; k++) begin
            s = (m_last + k) % NUM_SRC;
            if (src_have_msg[s]) begin
                m = hd[s] % MAXM;
                n = mlen[s][m];
                c = n[7:0];
                exp_q.push_back(8'hA5);  pop_q.push_back(1'b0);
                exp_q.push_back(n[7:0]); pop_q.push_back(1'b0);
                for (int b = 0; b < n; b++) begin
                    exp_q.push_back(mdat[s][m][b]);
                    pop_q.push_back(1'b1);
                    c = c ^ mdat[s][m][b];
                end
                exp_q.push_back(c);
                pop_q.push_back(n == 0);
                m_busy = 1'b1;
                m_src  = s;
                return;
            end
        end
    endtask

    // Monitor: compares DUT outputs against the scoreboard every cycle, away from the edge.
    always @(negedge clk) begin
        logic [NUM_SRC-1:0] exp_rd;
        exp_rd = '0;
        if (rst) begin
            chk("rdreq_during_rst", 32'(src_rdreq), 0);
            m_busy = 1'b0;
            m_last = NUM_SRC - 1;
            exp_q.delete();
            pop_q.delete();
        end else begin
            chk("tx_valid", 32'(tx_valid), 32'(m_busy));
            chk("busy", 32'(busy), 32'(m_busy));
            if (m_busy) begin
                chk("cur_src", 32'(cur_src), 32'(m_src));
                chk("tx_data", 32'(tx_data), 32'(exp_q[0]));
                if (tx_ready && pop_q[0]) exp_rd[m_src] = 1'b1;
            end
            chk("src_rdreq", 32'(src_rdreq), 32'(exp_rd));
            if (m_busy) begin
                if (tx_ready) begin
                    void'(exp_q.pop_front());
                    void'(pop_q.pop_front());
                    if (exp_q.size() == 0) begin
                        m_busy = 1'b0;
                        m_last = m_src;
                    end
                end
            end else begin
                model_grant();
            end
        end
    end

    initial begin
        int c;
        for (int s = 0; s < NUM_SRC; s++) begin
            hd[s]  = 0;
            tl[s]  = 0;
            pos[s] = 0;
            for (int m = 0; m < MAXM; m++) mlen[s][m] = 0;
        end
        drop      = '0;
        rdy_mode  = 0;
        rdy_phase = 0;
        tx_ready  = 1'b1;
        drive();

        // Reset
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("reset_cur_src", 32'(cur_src), 0);
        chk("reset_tx_valid", 32'(tx_valid), 0);
        chk("reset_busy", 32'(busy), 0);

        // Single source 1, len 1: A5 01 EA EB
        enq(1, 1, 8'hEA, 8'h00, 8'h00);
        wait_idle(50);

        // Backpressure: len 3, 11 22 33, ready pattern 1,0,0,...
        rdy_mode = 1;
        enq(0, 3, 8'h11, 8'h22, 8'h33);
        wait_idle(100);
        rdy_mode = 0;

        // Zero length on source 2: A5 00 00 with one pop at CHK accept
        enq(2, 0, 8'h00, 8'h00, 8'h00);
        wait_idle(50);

        // Source 0 drops have_msg during payload
        enq(0, 2, 8'h5A, 8'hC3, 8'h00);
        c = 0;
        while (c < 50 && !(m_busy && exp_q.size() <= 3)) begin
            tick();
            c++;
        end
        chk("drop_reach_pay", 32'(c < 50), 1);
        drop[0] = 1'b1;
        drive();
        wait_idle(100);
        drop[0] = 1'b0;
        drive();

        // Reset asserted mid-payload
        enq(1, 4, 8'h01, 8'h02, 8'h03);
        c = 0;
        while (c < 50 && !(m_busy && exp_q.size() <= 4)) begin
            tick();
            c++;
        end
        chk("rst_reach_pay", 32'(c < 50), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int s = 0; s < NUM_SRC; s++) begin
            hd[s]  = tl[s];
            pos[s] = 0;
        end
        drive();
        chk("post_rst_tx_valid", 32'(tx_valid), 0);
        chk("post_rst_busy", 32'(busy), 0);

        // After reset only source 3 requests: source 3 must win, frame starts with A5
        enq(3, 1, 8'h3C, 8'h00, 8'h00);
        wait_idle(50);

        // Round robin among 0, 2, 3 requesting continuously
        for (int r = 0; r < 3; r++) begin
            enq(0, 1, 8'(8'h40 + r), 8'h00, 8'h00);
            enq(2, 1, 8'(8'h60 + r), 8'h00, 8'h00);
            enq(3, 1, 8'(8'h70 + r), 8'h00, 8'h00);
        end
        wait_idle(200);

        // Maximum payload length
        rdy_mode = 2;
        enq(1, 255, 8'($urandom), 8'($urandom), 8'($urandom));
        wait_idle(1500);

        // Randomized traffic
        for (int i = 0; i < 2500; i++) begin
            int s;
            s = $urandom_range(0, NUM_SRC - 1);
            if ($urandom_range(0, 9) < 3 && (tl[s] - hd[s]) < MAXM - 2) begin
                enq(s, $urandom_range(0, 6), 8'($urandom), 8'($urandom), 8'($urandom));
            end
            tick();
        end
        wait_idle(3000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/msg_tx_arbiter.md
Name: msg_tx_arbiter

Overview:
- Downstream stage of the message-source blocks, such as the keep-alive responder and other reply generators.
- Each source raises have_msg, presents len and a show-ahead byte stream on data_out, and pops one byte per rdreq pulse.
- The arbiter grants sources round-robin and frames each message as SYNC, LEN, payload, CHK.
- Framed bytes go out over a valid/ready byte interface to the UART transmitter.

Parameters:
- NUM_SRC, 4: number of message sources, range 2..8.
- SRC_W, 2: index width, equal to clog2(NUM_SRC).
- SYNC_BYTE, 8'hA5: frame start byte.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- src_have_msg  in  NUM_SRC  bit i high means source i holds a message.
- src_len  in  8*NUM_SRC  payload length of source i, bits [8i+7:8i].
- src_data  in  8*NUM_SRC  current head byte of source i.
- src_rdreq  out  NUM_SRC  one-cycle pop strobe to source i.
- tx_data  out  8  byte to the transmitter.
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  transmitter accepts the byte when tx_valid and tx_ready are both high.
- busy  out  1  a frame is in progress.
- cur_src  out  SRC_W  index of the granted source, valid while busy.

Behaviour:
- Reset (on a clk edge with rst=1):
  - state=IDLE; rr_ptr=NUM_SRC-1, so source 0 wins first.
  - tx_valid=0, src_rdreq=0, busy=0, cur_src=0, chk=0, cnt=0.
- States: IDLE, HDR, LEN, PAY, CHK.
- IDLE:
  - If any src_have_msg bit is set, grant the first set index searching from rr_ptr+1 upward, wrapping modulo NUM_SRC.
  - On grant: latch cur_src and len_r = src_len[cur_src]; chk=len_r; cnt=0; go to HDR. busy goes high the next cycle.
  - Latency from have_msg rising to the first tx_valid is exactly 1 cycle.
- HDR: tx_valid=1, tx_data=SYNC_BYTE. On accept, go to LEN.
- LEN: tx_valid=1, tx_data=len_r. On accept, go to PAY if len_r!=0, else go to CHK.
- PAY:
  - tx_valid=1; tx_data=src_data[cur_src], passed combinationally, no extra latency.
  - On accept: src_rdreq[cur_src]=1 for exactly that cycle; chk ^= byte; cnt++.
  - When cnt reaches len_r-1 at accept, go to CHK.
- CHK:
  - tx_valid=1, tx_data=chk, the XOR of the LEN byte and all payload bytes.
  - On accept: rr_ptr=cur_src; state=IDLE; busy=0 the next cycle.
  - No back-to-back grant in the same cycle; IDLE always lasts at least 1 cycle.
- len_r=0: the frame is A5 00 00. One src_rdreq pulse is issued to the source in the CHK accept cycle so that its have_msg clears. This is the only rdreq not tied to a payload byte.
- tx_data must hold stable while tx_valid=1 and tx_ready=0. Never issue src_rdreq without an accept.
- Sources must hold src_len and src_data stable until popped. The arbiter ignores changes to src_len after the grant, because len_r is latched.
- A source dropping have_msg mid-frame is ignored; the frame completes using len_r.
- Other sources raising have_msg mid-frame wait for the next IDLE.
- rst=1 mid-frame aborts immediately to reset values. The partial frame is not completed and no rdreq is emitted in that cycle.
- Only one src_rdreq bit is ever high at a time.
- cnt is 8 bits, so a maximum payload of 255 bytes.

Test Plan:
- Single source: source 1 with len=1, data=EA, tx_ready held high.
  - Required: tx bytes A5 01 EA EB on 4 consecutive cycles starting 1 cycle after have_msg.
  - Required: src_rdreq[1] pulses once, aligned with the EA accept.
- Backpressure: len=3, data 11 22 33, tx_ready toggling 1,0,0,1,...
  - Required: every byte is held while not ready; exactly 3 rdreq pulses, each on an accept cycle.
  - Required: CHK=03^11^22^33=03.
- Round-robin: sources 0, 2 and 3 all request continuously with len=1.
  - Required: grant order 0,2,3,0,...
  - Required: after reset with only source 3 requesting, source 3 is granted.
- Zero length: source 2 with len=0.
  - Required: frame A5 00 00; src_rdreq[2] pulses once, in the CHK accept cycle; busy returns to 0.
- Mid-frame events:
  - Source 0 drops have_msg during PAY with len=2 → both payload bytes and CHK are still sent.
  - rst=1 asserted during PAY → next cycle tx_valid=0, busy=0, no rdreq; the following frame begins with A5.
